// File: rtl/addsub8_result_buf_if.sv
// Handshake and data bundle between an 8-bit add/sub stage, the result
// buffer, and whatever consumes the buffered result plus flags.
interface addsub8_result_buf_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_s;
   logic          in_co;
   logic          in_sub;
   logic          in_a7;
   logic          in_b7;

   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_s;
   logic          out_c;
   logic          out_z;
   logic          out_n;
   logic          out_v;

   logic [CW-1:0] count;
   logic          sticky_v;
   logic          clr_sticky;

   // buffer side
   modport slave (
      input  in_valid, in_s, in_co, in_sub, in_a7, in_b7,
      input  out_ready, clr_sticky,
      output in_ready, out_valid, out_s, out_c, out_z, out_n, out_v,
      output count, sticky_v
   );

   // producer/consumer side
   modport master (
      output in_valid, in_s, in_co, in_sub, in_a7, in_b7,
      output out_ready, clr_sticky,
      input  in_ready, out_valid, out_s, out_c, out_z, out_n, out_v,
      input  count, sticky_v
   );
endinterface

// File: rtl/addsub8_result_buf.sv
// Result buffer for an 8-bit add/sub stage: derives C/Z/N/V at push time,
// stores result and flags in an in-order circular buffer, and keeps a
// sticky overflow bit.
//
// state      | meaning
// -----------+------------------------------------------
// ST_EMPTY   | count == 0, out_valid low
// ST_PARTIAL | 0 < count < DEPTH
// ST_FULL    | count == DEPTH, in_ready only if popping
module addsub8_result_buf #(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   addsub8_result_buf_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } state_t;

   // entry layout: {v, n, z, c, s[7:0]}
   localparam int EW = 12;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   logic          v_in;
   logic [EW-1:0] entry_in;
   logic [EW-1:0] head;
   logic          sticky_q;

   logic [EW-1:0] mem [DEPTH];

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Flag derivation for the incoming result; overflow rule differs for add and subtract.
   always_comb begin
      v_in = 1'b0;
      if (bus.in_sub) begin
         v_in = (bus.in_a7 != bus.in_b7) && (bus.in_s[7] != bus.in_a7);
      end else begin
         v_in = (bus.in_a7 == bus.in_b7) && (bus.in_s[7] != bus.in_a7);
      end
      entry_in = {v_in, bus.in_s[7], (bus.in_s == 8'h00), bus.in_co, bus.in_s};
   end

   // Handshake decode, occupancy next-state and status outputs.
   always_comb begin
      pop           = 1'b0;
      push          = 1'b0;
      count_nxt     = count;
      state_nxt     = state;
      bus.out_valid = 1'b0;
      bus.in_ready  = 1'b1;

      bus.out_valid = (state != ST_EMPTY);
      pop           = bus.out_valid && bus.out_ready;
      // a full buffer still accepts when the head leaves in the same cycle
      bus.in_ready  = (state != ST_FULL) || pop;
      push          = bus.in_valid && bus.in_ready;

      if (push && !pop) begin
         count_nxt = count + 1'b1;
      end else if (pop && !push) begin
         count_nxt = count - 1'b1;
      end

      if (count_nxt == '0) begin
         state_nxt = ST_EMPTY;
      end else if (count_nxt == CW'(DEPTH)) begin
         state_nxt = ST_FULL;
      end else begin
         state_nxt = ST_PARTIAL;
      end
   end

   // State, occupancy and pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_EMPTY;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
      end
   end

   // Storage is not reset; stale contents are masked by out_valid.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wr_ptr] <= entry_in;
      end
   end

   // Sticky overflow: a new overflow push takes priority over a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else if (push && v_in) begin
         sticky_q <= 1'b1;
      end else if (bus.clr_sticky) begin
         sticky_q <= 1'b0;
      end
   end

   // Head entry straight from storage, forced to zero when nothing is held.
   always_comb begin
      head      = mem[rd_ptr];
      bus.out_s = '0;
      bus.out_c = 1'b0;
      bus.out_z = 1'b0;
      bus.out_n = 1'b0;
      bus.out_v = 1'b0;
      if (state != ST_EMPTY) begin
         bus.out_s = head[7:0];
         bus.out_c = head[8];
         bus.out_z = head[9];
         bus.out_n = head[10];
         bus.out_v = head[11];
      end
   end

   assign bus.count    = count;
   assign bus.sticky_v = sticky_q;

endmodule

// File: tb/tb_addsub8_result_buf.sv
// Bench for addsub8_result_buf: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based model.
module tb_addsub8_result_buf;
   localparam int DEPTH = 4;

   typedef struct {
      logic [7:0] s;
      logic       c;
      logic       z;
      logic       n;
      logic       v;
   } entry_t;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   entry_t     q[$];
   logic       m_sticky;

   addsub8_result_buf_if #(.DEPTH(DEPTH)) bus ();

   addsub8_result_buf #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: signed 8-bit arithmetic view of overflow, independent of bit tricks.
   function automatic logic ref_v(input logic [7:0] s, input logic sub, input logic a7, input logic b7);
      int a_sign;
      int b_sign;
      int r_sign;
      a_sign = a7 ? -1 : 1;
      b_sign = (sub ? (b7 ? 1 : -1) : (b7 ? -1 : 1));
      r_sign = s[7] ? -1 : 1;
      return (a_sign == b_sign) && (r_sign != a_sign);
   endfunction

   // Model update at each rising edge from the inputs the DUT sees.
   always @(posedge clk) begin
      logic   m_pop;
      logic   m_push;
      entry_t e;
      if (rst) begin
         q.delete();
         m_sticky = 1'b0;
      end else begin
         m_pop  = (q.size() != 0) && bus.out_ready;
         m_push = bus.in_valid && ((q.size() < DEPTH) || m_pop);
         e.s = bus.in_s;
         e.c = bus.in_co;
         e.z = (bus.in_s == 8'h00);
         e.n = bus.in_s[7];
         e.v = ref_v(bus.in_s, bus.in_sub, bus.in_a7, bus.in_b7);
         if (m_pop) void'(q.pop_front());
         if (m_push) q.push_back(e);
         if (m_push && e.v) m_sticky = 1'b1;
         else if (bus.clr_sticky) m_sticky = 1'b0;
      end
   end

   // Every-cycle comparison, sampled mid-cycle.
   always @(negedge clk) begin
      entry_t h;
      logic   ev;
      ev = (q.size() != 0);
      h = '{s: 8'h00, c: 1'b0, z: 1'b0, n: 1'b0, v: 1'b0};
      if (ev) h = q[0];
      chk("out_valid", int'(bus.out_valid), int'(ev));
      chk("in_ready",  int'(bus.in_ready),  int'((q.size() < DEPTH) || (ev && bus.out_ready)));
      chk("count",     int'(bus.count),     q.size());
      chk("sticky_v",  int'(bus.sticky_v),  int'(m_sticky));
      chk("out_s",     int'(bus.out_s),     int'(h.s));
      chk("out_flags", int'({bus.out_c, bus.out_z, bus.out_n, bus.out_v}), int'({h.c, h.z, h.n, h.v}));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input logic vld, input logic [7:0] s, input logic co,
                           input logic sub, input logic a7, input logic b7);
      bus.in_valid = vld;
      bus.in_s     = s;
      bus.in_co    = co;
      bus.in_sub   = sub;
      bus.in_a7    = a7;
      bus.in_b7    = b7;
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      m_sticky = 1'b0;
      rst      = 1'b1;
      drive_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.out_ready  = 1'b0;
      bus.clr_sticky = 1'b0;
      cyc();
      cyc();
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_in_ready",  int'(bus.in_ready),  1);
      chk("rst_count",     int'(bus.count),     0);
      rst = 1'b0;
      cyc();

      // zero result with carry
      drive_in(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc();
      drive_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("zero_valid", int'(bus.out_valid), 1);
      chk("zero_s",     int'(bus.out_s), 8'h00);
      chk("zero_czvn",  int'({bus.out_c, bus.out_z, bus.out_n, bus.out_v}), 4'b1100);
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;

      // 0x7F + 0x01 overflow
      drive_in(1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      drive_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ovf_n",      int'(bus.out_n), 1);
      chk("ovf_v",      int'(bus.out_v), 1);
      chk("ovf_sticky", int'(bus.sticky_v), 1);
      bus.clr_sticky = 1'b1;
      cyc();
      bus.clr_sticky = 1'b0;
      chk("clr_sticky", int'(bus.sticky_v), 0);
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;

      // fill, reject extra push, drain in order
      for (int i = 0; i < DEPTH; i++) begin
         drive_in(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
         cyc();
      end
      chk("full_count",    int'(bus.count), DEPTH);
      chk("full_in_ready", int'(bus.in_ready), 0);
      drive_in(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      drive_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("full_ignored", int'(bus.count), DEPTH);
      bus.out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_order", int'(bus.out_s), 8'h10 + i);
         cyc();
      end
      chk("drain_empty", int'(bus.out_valid), 0);
      bus.out_ready = 1'b0;

      // full pass-through across pointer wrap
      for (int i = 0; i < DEPTH; i++) begin
         drive_in(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0, 1'b0);
         cyc();
      end
      bus.out_ready = 1'b1;
      for (int k = 0; k < 2 * DEPTH; k++) begin
         drive_in(1'b1, 8'(8'h30 + k), 1'b0, 1'b0, 1'b0, 1'b0);
         chk("wrap_order", int'(bus.out_s), (k < DEPTH) ? (8'h20 + k) : (8'h30 + k - DEPTH));
         cyc();
         chk("wrap_count", int'(bus.count), DEPTH);
      end
      drive_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) cyc();
      bus.out_ready = 1'b0;

      // reset with push and pop in flight
      drive_in(1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      drive_in(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      drive_in(1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      chk("pre_rst_count",  int'(bus.count), 3);
      chk("pre_rst_sticky", int'(bus.sticky_v), 1);
      bus.out_ready = 1'b1;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      drive_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mid_rst_count",  int'(bus.count), 0);
      chk("mid_rst_valid",  int'(bus.out_valid), 0);
      chk("mid_rst_sticky", int'(bus.sticky_v), 0);

      // single push through an empty buffer with consumer ready
      drive_in(1'b1, 8'h42, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc();
      drive_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("single_valid", int'(bus.out_valid), 1);
      chk("single_count", int'(bus.count), 1);
      chk("single_s",     int'(bus.out_s), 8'h42);
      cyc();
      chk("single_gone",  int'(bus.count), 0);
      chk("single_empty", int'(bus.out_valid), 0);

      // randomized traffic
      for (int t = 0; t < 3000; t++) begin
         drive_in(1'($urandom_range(0, 2) != 0), 8'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 7) == 0) bus.in_s = 8'h00;
         bus.out_ready  = 1'($urandom_range(0, 2) != 0);
         bus.clr_sticky = ($urandom_range(0, 9) == 0);
         rst            = ($urandom_range(0, 99) == 0);
         cyc();
      end
      rst = 1'b0;
      drive_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.clr_sticky = 1'b0;
      cyc();
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
